// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register: valid/ready handshake, 2-entry skid buffer, global stall/flush.
// Optional performance counters are built only when PIPE_STAGE_ELASTIC_PERF_EN is defined.
module pipe_stage_elastic #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              stall,
  input  logic              flush,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flushed_entries
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state_p0, state_nxt;
  logic [DATA_W-1:0] head_data_p1, skid_data_p1;
  logic [CTRL_W-1:0] head_ctrl_p1, skid_ctrl_p1;
  logic              vld_p1;
  logic              acc_in, acc_out;
  logic              load_head, head_from_skid, load_skid;

  // Ready depends only on registered state plus the global stall.
  assign in_ready  = (state_p0 != FULL) && !stall;
  assign vld_p1    = (state_p0 != EMPTY);
  assign acc_in    = in_valid && in_ready;
  assign acc_out   = vld_p1 && out_ready && !stall;

  always_comb begin
    state_nxt      = state_p0;
    load_head      = 1'b0;
    head_from_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_p0)
      EMPTY: begin
        if (acc_in) begin
          state_nxt = ONE;
          load_head = 1'b1;
        end
      end
      ONE: begin
        if (acc_in && acc_out) begin
          load_head = 1'b1;
        end else if (acc_in) begin
          state_nxt = FULL;
          load_skid = 1'b1;
        end else if (acc_out) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (acc_out) begin
          state_nxt      = ONE;
          load_head      = 1'b1;
          head_from_skid = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
    if (flush) begin
      state_nxt = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_p0 <= EMPTY;
    end else begin
      state_p0 <= state_nxt;
    end
  end

  // Stage boundary: head/skid storage; validity lives in the state register.
  always_ff @(posedge clk) begin
    if (load_head) begin
      head_data_p1 <= head_from_skid ? skid_data_p1 : in_data;
      head_ctrl_p1 <= head_from_skid ? skid_ctrl_p1 : in_ctrl;
    end
    if (load_skid) begin
      skid_data_p1 <= in_data;
      skid_ctrl_p1 <= in_ctrl;
    end
  end

  assign out_valid = vld_p1;
  assign out_data  = vld_p1 ? head_data_p1 : '0;
  assign out_ctrl  = vld_p1 ? head_ctrl_p1 : '0;

  always_comb begin
    case (state_p0)
      ONE:     occupancy = 2'd1;
      FULL:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

`ifdef PIPE_STAGE_ELASTIC_PERF_EN
  logic [CNT_W-1:0] stall_cnt_p1, flush_cnt_p1;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {{(CNT_W-1){1'b0}}, b};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_p1 <= '0;
      flush_cnt_p1 <= '0;
    end else begin
      if (vld_p1 && (!out_ready || stall)) begin
        stall_cnt_p1 <= sat_add(stall_cnt_p1, 2'd1);
      end
      if (flush) begin
        flush_cnt_p1 <= sat_add(flush_cnt_p1, occupancy);
      end
    end
  end

  assign stall_cycles    = stall_cnt_p1;
  assign flushed_entries = flush_cnt_p1;
`else
  assign stall_cycles    = '0;
  assign flushed_entries = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed self-checking bench for pipe_stage_elastic (default 32/4/16 configuration).
`timescale 1ns/1ps
module tb_pipe_stage_elastic;

  localparam int DATA_W = 32;
  localparam int CTRL_W = 4;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic              stall;
  logic              flush;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  stall_cycles;
  logic [CNT_W-1:0]  flushed_entries;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_stage_elastic #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .stall(stall), .flush(flush), .occupancy(occupancy),
    .stall_cycles(stall_cycles), .flushed_entries(flushed_entries)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_head(input string tag, input logic v, input logic [31:0] d,
                          input logic [3:0] c, input logic [1:0] occ);
    chk({tag, ".valid"}, 64'(out_valid), 64'(v));
    chk({tag, ".data"},  64'(out_data),  64'(d));
    chk({tag, ".ctrl"},  64'(out_ctrl),  64'(c));
    chk({tag, ".occ"},   64'(occupancy), 64'(occ));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  int perf;

  initial begin
`ifdef PIPE_STAGE_ELASTIC_PERF_EN
    perf = 1;
`else
    perf = 0;
`endif
    rst = 1'b0; in_valid = 1'b1; in_data = 32'h55; in_ctrl = 4'hF;
    out_ready = 1'b1; stall = 1'b0; flush = 1'b0;

    // Reset held with in_valid high: nothing enters
    tick();
    tick();
    chk_head("reset", 1'b0, 32'h0, 4'h0, 2'd0);
    chk("reset.stall_cycles", 64'(stall_cycles), 64'd0);
    chk("reset.flushed", 64'(flushed_entries), 64'd0);
    in_valid = 1'b0;
    rst = 1'b1;
    chk("reset.in_ready", 64'(in_ready), 64'd1);

    // Streaming 1..4, full throughput
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_data = 32'(i); in_ctrl = 4'(i);
      tick();
      chk_head($sformatf("stream%0d", i), 1'b1, 32'(i), 4'(i), 2'd1);
      chk($sformatf("stream%0d.in_ready", i), 64'(in_ready), 64'd1);
    end
    in_valid = 1'b0;
    tick();
    chk_head("stream_drain", 1'b0, 32'h0, 4'h0, 2'd0);

    // Backpressure: A, B absorbed, C held upstream
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hA; in_ctrl = 4'h1;
    tick();
    chk_head("bp_a", 1'b1, 32'hA, 4'h1, 2'd1);
    in_data = 32'hB; in_ctrl = 4'h2;
    tick();
    chk_head("bp_full", 1'b1, 32'hA, 4'h1, 2'd2);
    in_data = 32'hC; in_ctrl = 4'h3;
    chk("bp_full.in_ready", 64'(in_ready), 64'd0);
    tick();
    chk_head("bp_hold", 1'b1, 32'hA, 4'h1, 2'd2);
    out_ready = 1'b1;
    chk("bp_release.in_ready", 64'(in_ready), 64'd0);
    tick();
    chk_head("bp_out_b", 1'b1, 32'hB, 4'h2, 2'd1);
    chk("bp_out_b.in_ready", 64'(in_ready), 64'd1);
    tick();
    chk_head("bp_out_c", 1'b1, 32'hC, 4'h3, 2'd1);
    in_valid = 1'b0;
    tick();
    chk_head("bp_drain", 1'b0, 32'h0, 4'h0, 2'd0);

    // Stall while FULL; counters restarted by a reset pulse
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h11; in_ctrl = 4'h1;
    tick();
    in_data = 32'h22; in_ctrl = 4'h2;
    tick();
    in_valid = 1'b0;
    chk_head("st_full", 1'b1, 32'h11, 4'h1, 2'd2);
    chk("st_full.stall_cycles", 64'(stall_cycles), 64'(perf * 1));
    stall = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_head($sformatf("st_hold%0d", i), 1'b1, 32'h11, 4'h1, 2'd2);
      chk($sformatf("st_hold%0d.in_ready", i), 64'(in_ready), 64'd0);
    end
    chk("st.stall_cycles", 64'(stall_cycles), 64'(perf * 4));
    stall = 1'b0;
    tick();
    chk_head("st_release", 1'b1, 32'h22, 4'h2, 2'd1);
    chk("st_release.stall_cycles", 64'(stall_cycles), 64'(perf * 4));

    // Flush from FULL with a same-cycle input that must be dropped
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h33; in_ctrl = 4'h3;
    tick();
    chk_head("fl_full", 1'b1, 32'h22, 4'h2, 2'd2);
    in_data = 32'h44; in_ctrl = 4'h4; flush = 1'b1;
    tick();
    chk_head("fl_empty", 1'b0, 32'h0, 4'h0, 2'd0);
    chk("fl.flushed", 64'(flushed_entries), 64'(perf * 2));
    flush = 1'b0; in_valid = 1'b0;
    tick();
    chk_head("fl_dropped", 1'b0, 32'h0, 4'h0, 2'd0);

    // Flush and stall together from ONE: flush wins
    in_valid = 1'b1; in_data = 32'h66; in_ctrl = 4'h6;
    tick();
    chk_head("fs_one", 1'b1, 32'h66, 4'h6, 2'd1);
    in_valid = 1'b0; stall = 1'b1; flush = 1'b1;
    tick();
    chk_head("fs_empty", 1'b0, 32'h0, 4'h0, 2'd0);
    chk("fs.flushed", 64'(flushed_entries), 64'(perf * 3));
    stall = 1'b0; flush = 1'b0;

    // Async reset mid-stream, then accept on the first edge after release
    in_valid = 1'b1; in_data = 32'h70; in_ctrl = 4'h7;
    tick();
    rst = 1'b0;
    #1;
    chk_head("async_rst", 1'b0, 32'h0, 4'h0, 2'd0);
    tick();
    rst = 1'b1;
    in_data = 32'h77; in_ctrl = 4'h5; out_ready = 1'b1;
    tick();
    chk_head("post_rst", 1'b1, 32'h77, 4'h5, 2'd1);
    chk("post_rst.flushed", 64'(flushed_entries), 64'd0);
    in_valid = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
